// File: rtl/line_ram_ctrl.sv
// Line-granular backing RAM for cache fills/write-backs with per-byte strobes and bounds/alignment checking.
// Latency: a request accepted at edge k raises mem_ready_o for the single cycle after edge k+LATENCY.
// Backpressure: requests are sampled only in IDLE; mem_valid_i during WAIT/DONE is dropped, not queued.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   mem_valid_i/addr/rw/wdata/wstrb   request (byte i of wdata/wstrb maps to addr+i)
//   mem_ready_o                  one-cycle response pulse
//   mem_rdata_o                  read line, held until next response or reset
//   dmem_error_o                 misaligned or out-of-range request, valid with mem_ready_o
//   mem_busy_o                   high whenever a request is in flight (FSM not IDLE)
module line_ram_ctrl #(
    parameter int ADDR_W     = 64,
    parameter int LINE_BYTES = 32,
    parameter int MEM_BYTES  = 2048,
    parameter int LATENCY    = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    mem_valid_i,
    input  logic [ADDR_W-1:0]       mem_addr_i,
    input  logic                    mem_rw_i,
    input  logic [8*LINE_BYTES-1:0] mem_wdata_i,
    input  logic [LINE_BYTES-1:0]   mem_wstrb_i,
    output logic                    mem_ready_o,
    output logic [8*LINE_BYTES-1:0] mem_rdata_o,
    output logic                    dmem_error_o,
    output logic                    mem_busy_o
);

    localparam int DATA_W = 8 * LINE_BYTES;
    localparam int LINES  = MEM_BYTES / LINE_BYTES;
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int IDX_W  = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_BYTES - 1);
    localparam logic [ADDR_W:0]   LINE_SZ  = (ADDR_W + 1)'(LINE_BYTES);
    localparam logic [ADDR_W:0]   MEM_SZ   = (ADDR_W + 1)'(MEM_BYTES);
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                rw_q, rw_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [LINE_BYTES-1:0] wstrb_q, wstrb_d;
    logic                req_err_q, req_err_d;
    logic                ready_q, ready_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic [DATA_W-1:0]   mem_q [LINES];
    logic                mem_we;

    // Range check in ADDR_W+1 bits so a line near the top of the address space cannot wrap into range.
    logic [ADDR_W:0]     end_addr;
    logic                misaligned;
    logic                out_of_range;

    always_comb begin
        end_addr     = {1'b0, mem_addr_i} + LINE_SZ;
        misaligned   = (mem_addr_i & OFF_MASK) != '0;
        out_of_range = end_addr > MEM_SZ;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        rw_d      = rw_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        req_err_d = req_err_q;
        ready_d   = 1'b0;
        err_d     = 1'b0;
        rdata_d   = rdata_q;
        mem_we    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (mem_valid_i) begin
                    idx_d     = mem_addr_i[OFF_W +: IDX_W];
                    rw_d      = mem_rw_i;
                    wdata_d   = mem_wdata_i;
                    wstrb_d   = mem_wstrb_i;
                    req_err_d = misaligned | out_of_range;
                    cnt_d     = CNT_INIT;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    ready_d = 1'b1;
                    err_d   = req_err_q;
                    rdata_d = '0;
                    if (!req_err_q) begin
                        if (rw_q) begin
                            mem_we = 1'b1;
                        end else begin
                            rdata_d = mem_q[idx_q];
                        end
                    end
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            rw_q      <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            req_err_q <= 1'b0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            rw_q      <= rw_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            req_err_q <= req_err_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
        end
    end

    // Storage is not reset; a reset landing on the commit edge suppresses the write.
    always_ff @(posedge clk_i) begin
        if (mem_we && !rst_i) begin
            for (int i = 0; i < LINE_BYTES; i++) begin
                if (wstrb_q[i]) begin
                    mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign mem_ready_o  = ready_q;
    assign dmem_error_o = err_q;
    assign mem_rdata_o  = rdata_q;
    assign mem_busy_o   = (state_q != S_IDLE);

endmodule

// File: tb/tb_line_ram_ctrl.sv
// Bench for line_ram_ctrl: byte-array model plus directed vectors on a LATENCY=4 instance,
// and a handshake-spacing check on a LATENCY=1 instance.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_line_ram_ctrl;

    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         mem_valid = 1'b0;
    logic         v1 = 1'b0;
    logic [63:0]  mem_addr = '0;
    logic         mem_rw = 1'b0;
    logic [255:0] mem_wdata = '0;
    logic [31:0]  mem_wstrb = '0;

    logic         ready0, err0, busy0;
    logic [255:0] rdata0;
    logic         ready1, err1, busy1;
    logic [255:0] rdata1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    line_ram_ctrl #(.ADDR_W(64), .LINE_BYTES(32), .MEM_BYTES(2048), .LATENCY(LAT)) dut (
        .clk_i(clk), .rst_i(rst), .mem_valid_i(mem_valid), .mem_addr_i(mem_addr),
        .mem_rw_i(mem_rw), .mem_wdata_i(mem_wdata), .mem_wstrb_i(mem_wstrb),
        .mem_ready_o(ready0), .mem_rdata_o(rdata0), .dmem_error_o(err0), .mem_busy_o(busy0)
    );

    line_ram_ctrl #(.ADDR_W(64), .LINE_BYTES(32), .MEM_BYTES(2048), .LATENCY(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .mem_valid_i(v1), .mem_addr_i(mem_addr),
        .mem_rw_i(mem_rw), .mem_wdata_i(mem_wdata), .mem_wstrb_i(mem_wstrb),
        .mem_ready_o(ready1), .mem_rdata_o(rdata1), .dmem_error_o(err1), .mem_busy_o(busy1)
    );

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model (LATENCY=4 instance) ----------------
    // Time is tracked in edge numbers: a request accepted at edge a answers at edge a+LAT,
    // keeps the block busy through edge a+LAT, and the next acceptance is possible at a+LAT+2.
    logic [7:0]   mm [2048];
    bit           model_ok = 0;
    int           e = 0;
    int           m_next = 0;
    int           m_resp = 0;
    bit           m_pend = 0;
    logic         m_ready = 0;
    logic         m_err = 0;
    logic         m_busy = 0;
    logic [255:0] m_rdata = '0;
    logic         p_rw, p_err;
    int           p_addr;
    logic [255:0] p_wdata;
    logic [31:0]  p_wstrb;

    initial forever begin
        @(posedge clk);
        e++;
        if (rst) begin
            model_ok = 1;
            m_pend   = 0;
            m_next   = e + 1;
            m_ready  = 0;
            m_err    = 0;
            m_rdata  = '0;
        end else begin
            m_ready = 0;
            m_err   = 0;
            if (m_pend && e == m_resp) begin
                m_pend  = 0;
                m_ready = 1;
                m_err   = p_err;
                m_rdata = '0;
                if (!p_err) begin
                    for (int i = 0; i < 32; i++) begin
                        if (p_rw) begin
                            if (p_wstrb[i]) mm[p_addr + i] = p_wdata[8*i +: 8];
                        end else begin
                            m_rdata[8*i +: 8] = mm[p_addr + i];
                        end
                    end
                end
            end
            if (mem_valid && e >= m_next) begin
                p_rw    = mem_rw;
                p_wdata = mem_wdata;
                p_wstrb = mem_wstrb;
                p_err   = (mem_addr % 64'd32 != 64'd0) ||
                          (({1'b0, mem_addr} + 65'd32) > 65'd2048);
                p_addr  = p_err ? 0 : int'(mem_addr[10:0]);
                m_pend  = 1;
                m_resp  = e + LAT;
                m_next  = e + LAT + 2;
            end
        end
        m_busy = (e + 1 < m_next);
    end

    initial forever begin
        @(negedge clk);
        if (model_ok) begin
            chk("mdl_ready", {255'd0, ready0}, {255'd0, m_ready});
            chk("mdl_busy",  {255'd0, busy0},  {255'd0, m_busy});
            chk("mdl_rdata", rdata0, m_rdata);
            if (m_ready) chk("mdl_error", {255'd0, err0}, {255'd0, m_err});
        end
    end

    // ---------------- directed stimulus ----------------
    // Drives one request on the LATENCY=4 instance; returns at the falling edge where ready is seen,
    // with lat = number of cycles from acceptance to the response.
    task automatic do_req(input logic rw, input logic [63:0] addr, input logic [255:0] wd,
                          input logic [31:0] ws, output logic [255:0] rd, output logic er,
                          output int lat);
        @(negedge clk);
        mem_valid = 1'b1;
        mem_rw    = rw;
        mem_addr  = addr;
        mem_wdata = wd;
        mem_wstrb = ws;
        @(posedge clk);
        @(negedge clk);
        mem_valid = 1'b0;
        lat = 0;
        while (!ready0 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rd = rdata0;
        er = err0;
    endtask

    localparam logic [255:0] RAMP =
        256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100;
    localparam logic [255:0] RAMP_P =
        256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a090807060504ffffffff;

    initial begin : wdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [255:0] rd;
        logic         er;
        int           lat;
        int           cnt, p1, p2, low;

        // 1. reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t1_ready", {255'd0, ready0}, 256'd0);
            chk("t1_error", {255'd0, err0},   256'd0);
            chk("t1_busy",  {255'd0, busy0},  256'd0);
            chk("t1_rdata", rdata0,           256'd0);
        end

        // 2. full-line write then read
        do_req(1'b1, 64'h40, RAMP, 32'hffff_ffff, rd, er, lat);
        chk("t2_wr_lat", 256'(lat), 256'd4);
        chk("t2_wr_err", {255'd0, er}, 256'd0);
        chk("t2_wr_rdata", rd, 256'd0);
        do_req(1'b0, 64'h40, '0, '0, rd, er, lat);
        chk("t2_rd_lat", 256'(lat), 256'd4);
        chk("t2_rd_err", {255'd0, er}, 256'd0);
        chk("t2_rd_data", rd, RAMP);

        // 3. partial strobe
        do_req(1'b1, 64'h40, {32{8'hff}}, 32'h0000_000f, rd, er, lat);
        chk("t3_wr_err", {255'd0, er}, 256'd0);
        do_req(1'b0, 64'h40, '0, '0, rd, er, lat);
        chk("t3_rd_data", rd, RAMP_P);

        // 4. bounds and alignment
        do_req(1'b1, 64'h7e0, {32{8'h3c}}, 32'hffff_ffff, rd, er, lat);
        chk("t4_last_wr_err", {255'd0, er}, 256'd0);
        do_req(1'b0, 64'h7e0, '0, '0, rd, er, lat);
        chk("t4_last_rd_err", {255'd0, er}, 256'd0);
        chk("t4_last_rd_data", rd, {32{8'h3c}});
        do_req(1'b0, 64'h800, '0, '0, rd, er, lat);
        chk("t4_oob_lat", 256'(lat), 256'd4);
        chk("t4_oob_err", {255'd0, er}, 256'd1);
        chk("t4_oob_rdata", rd, 256'd0);
        do_req(1'b1, 64'h44, {32{8'hee}}, 32'hffff_ffff, rd, er, lat);
        chk("t4_mis_err", {255'd0, er}, 256'd1);
        do_req(1'b0, 64'h40, '0, '0, rd, er, lat);
        chk("t4_mis_nochange", rd, RAMP_P);
        do_req(1'b0, 64'hffff_ffff_ffff_ffe0, '0, '0, rd, er, lat);
        chk("t4_wrap_err", {255'd0, er}, 256'd1);
        chk("t4_wrap_rdata", rd, 256'd0);

        // 5. reset during WAIT aborts a write
        do_req(1'b1, 64'h80, {32{8'h55}}, 32'hffff_ffff, rd, er, lat);
        chk("t5_pre_err", {255'd0, er}, 256'd0);
        @(negedge clk);
        mem_valid = 1'b1;
        mem_rw    = 1'b1;
        mem_addr  = 64'h80;
        mem_wdata = {32{8'haa}};
        mem_wstrb = 32'hffff_ffff;
        @(posedge clk);
        @(negedge clk);
        mem_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ready0) cnt++;
        end
        chk("t5_no_ready", 256'(cnt), 256'd0);
        do_req(1'b0, 64'h80, '0, '0, rd, er, lat);
        chk("t5_prior_data", rd, {32{8'h55}});

        // 6a. valid held high on the LATENCY=4 instance
        @(negedge clk);
        mem_rw = 1'b0;
        mem_addr = 64'h40;
        mem_valid = 1'b1;
        cnt = 0; p1 = -1; p2 = -1; low = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 7) mem_valid = 1'b0;
            if (ready0) begin
                cnt++;
                if (p1 < 0) p1 = n; else p2 = n;
            end
            if (!busy0 && p1 >= 0 && p2 < 0) low++;
        end
        chk("t6_l4_pulses", 256'(cnt), 256'd2);
        chk("t6_l4_spacing", 256'(p2 - p1), 256'd6);
        chk("t6_l4_idle_gap", 256'(low), 256'd1);

        // 6b. valid held high on the LATENCY=1 instance
        @(negedge clk);
        v1 = 1'b1;
        cnt = 0; p1 = -1; p2 = -1; low = 0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (n == 4) v1 = 1'b0;
            if (ready1) begin
                cnt++;
                if (p1 < 0) p1 = n; else p2 = n;
            end
            if (!busy1 && p1 >= 0 && p2 < 0) low++;
        end
        chk("t6_l1_pulses", 256'(cnt), 256'd2);
        chk("t6_l1_spacing", 256'(p2 - p1), 256'd3);
        chk("t6_l1_idle_gap", 256'(low), 256'd1);
        chk("t6_l1_first_lat", 256'(p1), 256'd2);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/line_ram_ctrl.md
Name: line_ram_ctrl

Overview:
- Parametrised line-granular backing memory that sits behind the instruction and data caches and serves whole-line fills and write-backs.
- Generalises the single-cycle line RAM in four ways:
  - line width, memory size and access latency are parameters;
  - per-byte write strobes;
  - registered, multi-cycle request/ready handshake driven by an FSM;
  - bounds and alignment error reporting.

Parameters:
- ADDR_W, 64, width of the byte address.
- LINE_BYTES, 32, bytes per transfer; must be a power of two.
- MEM_BYTES, 2048, memory size in bytes; must be a multiple of LINE_BYTES.
- LATENCY, 4, cycles from request acceptance to response; must be >= 1.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous reset, active-high.
- mem_valid_i  in  1  request strobe; sampled only in IDLE.
- mem_addr_i  in  ADDR_W  byte address of the line.
- mem_rw_i  in  1  1 = write, 0 = read.
- mem_wdata_i  in  8*LINE_BYTES  write data; byte i is at bits [8i+7:8i] and maps to address addr+i.
- mem_wstrb_i  in  LINE_BYTES  per-byte write enable.
- mem_ready_o  out  1  one-cycle response pulse.
- mem_rdata_o  out  8*LINE_BYTES  read data; byte order as for mem_wdata_i.
- dmem_error_o  out  1  error flag; valid only while mem_ready_o = 1.
- mem_busy_o  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (rst_i = 1 at a rising edge):
  - FSM goes to IDLE.
  - mem_ready_o, dmem_error_o and mem_rdata_o go to 0; mem_busy_o goes to 0.
  - Memory array contents are NOT reset.
  - Reset during WAIT aborts the request: no write is committed and no response is produced.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - If mem_valid_i = 1 at an edge, latch addr, rw, wdata and wstrb; compute the error flag; load counter = LATENCY-1; go to WAIT.
  - Otherwise stay in IDLE.
- Error flag:
  - Set if (addr mod LINE_BYTES) != 0 (misaligned), or if addr + LINE_BYTES > MEM_BYTES.
  - The sum is computed in ADDR_W+1 bits so that it cannot wrap.
- WAIT:
  - Counter nonzero: decrement it.
  - Counter zero: commit and go to DONE with mem_ready_o = 1 and dmem_error_o = latched error.
  - Commit rules:
    - write without error: update every byte i with strobe[i] = 1; leave other bytes untouched; mem_rdata_o = 0;
    - read without error: mem_rdata_o = line at addr;
    - any error: no array update; mem_rdata_o = 0.
- DONE:
  - Unconditionally go to IDLE.
  - mem_ready_o and dmem_error_o return to 0.
  - mem_rdata_o holds its value until the next response or reset.
- Timing:
  - Request sampled at edge k gives mem_ready_o high for exactly the one cycle after edge k+LATENCY.
  - The earliest next acceptance is at edge k+LATENCY+2, so sustained throughput is one request per LATENCY+2 cycles.
- mem_valid_i in WAIT or DONE is ignored and not queued.
  - A requester holding valid past ready therefore issues a new request, which is accepted in the next IDLE cycle.
- A read following a write to the same line returns the written data, since the commit precedes any later acceptance.
- Strobe all-zero on a write: a legal no-op; the response is still returned.

Test Plan:
(LATENCY = 4, LINE_BYTES = 32, MEM_BYTES = 2048 unless noted)
1. Reset: assert rst_i for 2 cycles, then release -> mem_ready_o, dmem_error_o and mem_busy_o are 0 and mem_rdata_o = 0; with valid = 0, outputs stay 0.
2. Full-line write then read:
   - write addr 0x40, data {32 bytes 0x00..0x1F}, strobe all-ones -> ready pulses 1 cycle after edge k+4 with error = 0;
   - read 0x40 -> rdata = 0x1F1E...0100, ready exactly 4 cycles after acceptance.
3. Partial strobe: after test 2, write 0x40 with all bytes 0xFF, strobe 0x0000000F; then read 0x40 -> bytes 0-3 = 0xFF, bytes 4-31 unchanged (0x04..0x1F).
4. Bounds and alignment:
   - read 0x7E0 -> error = 0;
   - read 0x800 -> ready = 1, error = 1, rdata = 0;
   - write 0x44 -> error = 1, and a later read of 0x40 shows no change;
   - addr 0xFFFF_FFFF_FFFF_FFE0 -> error = 1 (no wrap).
5. Reset mid-write: issue write 0x80 with 0xAA..AA; assert rst_i on the 2nd WAIT cycle -> no ready pulse; a later read of 0x80 returns the prior contents.
6. Valid held high:
   - valid held across two reads -> acceptances spaced exactly LATENCY+2 = 6 cycles, exactly two ready pulses, mem_busy_o low for one cycle between requests;
   - repeat with LATENCY = 1 -> spacing 3 cycles.
